// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Purpose: operation encodings and op-field width shared by the pipelined ALU and its segments.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SLT = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOR = 3'b101;

endpackage

// File: rtl/alu_segment.sv
// Module: alu_segment
// Purpose: combinational SEG_W-bit ALU slice; one instance per pipeline stage.
// Ports:
//   a, b      SEG_W-bit operand slices
//   cin       carry into the slice LSB
//   bnegate   invert b before use
//   op        operation code (alu_pkg)
//   res       slice result (raw sum for ADD and SLT; SLT fix-up happens at the pipe output)
//   cout      carry out of the slice MSB
//   c_msb_in  carry into the slice MSB (used for overflow in the top slice)
module alu_segment
  import alu_pkg::*;
#(
  parameter int unsigned SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  input  logic             bnegate,
  input  logic [OP_W-1:0]  op,
  output logic [SEG_W-1:0] res,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SEG_W-1:0] w_b;
  logic [SEG_W-1:0] w_sum;
  logic [SEG_W:0]   w_add;

  assign w_b   = bnegate ? ~b : b;
  assign w_add = {1'b0, a} + {1'b0, w_b} + (SEG_W+1)'(cin);
  assign w_sum = w_add[SEG_W-1:0];
  assign cout  = w_add[SEG_W];
  // Carry into MSB recovered from the MSB sum bit: s = a ^ b ^ c
  assign c_msb_in = a[SEG_W-1] ^ w_b[SEG_W-1] ^ w_sum[SEG_W-1];

  always_comb begin
    res = '0;
    case (op)
      OP_AND:         res = a & w_b;
      OP_OR:          res = a | w_b;
      OP_ADD, OP_SLT: res = w_sum;
      OP_XOR:         res = a ^ w_b;
      OP_NOR:         res = ~(a | w_b);
      default:        res = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_nbit.sv
// Module: alu_pipe_nbit
// Purpose: WIDTH-bit pipelined ALU, carry chain split into SEG_W-bit stages, valid/ready on both sides.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (beat taken when both high)
//   a, b, cin, bnegate, op operand beat
//   out_valid / out_ready result handshake (beat leaves when both high)
//   result, cout, overflow, zero, negative  result beat and flags
module alu_pipe_nbit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             bnegate,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned STAGES = WIDTH / SEG_W;
  localparam int unsigned LAST   = STAGES - 1;

  // Per-stage registers: valid, operand skew, partial result, carry
  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_res [STAGES];
  logic [OP_W-1:0]   r_op  [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_cmsb;
  logic [STAGES-1:0] r_bneg;

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_up;

  logic [WIDTH-1:0]  w_a_in   [STAGES];
  logic [WIDTH-1:0]  w_b_in   [STAGES];
  logic [WIDTH-1:0]  w_res_in [STAGES];
  logic [WIDTH-1:0]  w_res_nx [STAGES];
  logic [OP_W-1:0]   w_op_in  [STAGES];
  logic [SEG_W-1:0]  w_seg_res[STAGES];
  logic [STAGES-1:0] w_cin_in;
  logic [STAGES-1:0] w_bneg_in;
  logic [STAGES-1:0] w_seg_co;
  logic [STAGES-1:0] w_seg_cmsb;

  // Handshake: advance ripples back from the output; a bubble anywhere lets everything above it move
  always_comb begin
    w_adv  = '0;
    w_load = '0;
    w_up   = '0;
    w_adv[LAST] = r_v[LAST] & out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      w_adv[k] = r_v[k] & (~r_v[k+1] | w_adv[k+1]);
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      w_load[k] = ~r_v[k] | w_adv[k];
    end
    w_up[0] = in_valid & w_load[0];
    for (int k = 1; k < int'(STAGES); k++) begin
      w_up[k] = w_adv[k-1];
    end
  end

  assign in_ready = w_load[0];

  // Stage k sees either the input ports or stage k-1's registers, and fills in its own slice
  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a_in[k]    = a;
      assign w_b_in[k]    = b;
      assign w_res_in[k]  = '0;
      assign w_op_in[k]   = op;
      assign w_cin_in[k]  = cin;
      assign w_bneg_in[k] = bnegate;
    end else begin : g_next
      assign w_a_in[k]    = r_a[k-1];
      assign w_b_in[k]    = r_b[k-1];
      assign w_res_in[k]  = r_res[k-1];
      assign w_op_in[k]   = r_op[k-1];
      assign w_cin_in[k]  = r_c[k-1];
      assign w_bneg_in[k] = r_bneg[k-1];
    end

    alu_segment #(.SEG_W(SEG_W)) u_seg (
      .a        (w_a_in[k][k*SEG_W +: SEG_W]),
      .b        (w_b_in[k][k*SEG_W +: SEG_W]),
      .cin      (w_cin_in[k]),
      .bnegate  (w_bneg_in[k]),
      .op       (w_op_in[k]),
      .res      (w_seg_res[k]),
      .cout     (w_seg_co[k]),
      .c_msb_in (w_seg_cmsb[k])
    );

    assign w_res_nx[k] = (w_res_in[k] & ~(WIDTH'({SEG_W{1'b1}}) << (k*SEG_W)))
                       | (WIDTH'(w_seg_res[k]) << (k*SEG_W));
  end

  // Control and output-visible state (reset)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v    <= '0;
      r_c    <= '0;
      r_cmsb <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        r_res[k] <= '0;
        r_op[k]  <= OP_AND;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (w_load[k]) begin
          r_v[k] <= w_up[k];
        end
        if (w_up[k]) begin
          r_res[k]  <= w_res_nx[k];
          r_op[k]   <= w_op_in[k];
          r_c[k]    <= w_seg_co[k];
          r_cmsb[k] <= w_seg_cmsb[k];
        end
      end
    end
  end

  // Operand skew registers (no reset needed)
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(STAGES); k++) begin
      if (w_up[k]) begin
        r_a[k]    <= w_a_in[k];
        r_b[k]    <= w_b_in[k];
        r_bneg[k] <= w_bneg_in[k];
      end
    end
  end

  // Output: SLT fix-up and flags from the last stage's registered full result
  logic w_ovf_raw;
  logic w_slt;
  logic w_is_add;

  assign w_ovf_raw = r_cmsb[LAST] ^ r_c[LAST];
  assign w_slt     = r_res[LAST][WIDTH-1] ^ w_ovf_raw;
  assign w_is_add  = (r_op[LAST] == OP_ADD);

  assign out_valid = r_v[LAST];
  assign result    = (r_op[LAST] == OP_SLT) ? WIDTH'(w_slt) : r_res[LAST];
  assign cout      = out_valid & w_is_add & r_c[LAST];
  assign overflow  = out_valid & w_is_add & w_ovf_raw;
  assign zero      = out_valid & (result == '0);
  assign negative  = out_valid & result[WIDTH-1];

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// Testbench: tb_alu_pipe_nbit
// Purpose: scoreboard bench for alu_pipe_nbit (WIDTH=16, SEG_W=4): expected beats queued at accept,
// compared in order at drain; also checks in_ready, stall stability, latency and reset flush.
module tb_alu_pipe_nbit;

  localparam int W  = 16;
  localparam int SW = 4;
  localparam int ST = W / SW;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          bnegate;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          cout;
  logic          overflow;
  logic          zero;
  logic          negative;

  alu_pipe_nbit #(.WIDTH(W), .SEG_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .bnegate   (bnegate),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total;
  int          n_bad;
  logic [19:0] q[$];
  int          or_mode;
  int          cyc;
  logic        prev_stall;
  logic [19:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: {result[15:0], cout, overflow, zero, negative}
  function automatic logic [19:0] model(input logic [2:0] o, input logic [W-1:0] xa,
                                        input logic [W-1:0] xb, input logic xc, input logic xn);
    logic [W-1:0] bb;
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    bb = xn ? ~xb : xb;
    s  = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, xc};
    v  = (xa[W-1] == bb[W-1]) && (s[W-1] != xa[W-1]);
    c  = 1'b0;
    r  = '0;
    case (o)
      3'b000: r = xa & bb;
      3'b001: r = xa | bb;
      3'b010: begin r = s[W-1:0]; c = s[W]; end
      3'b011: r = {{(W-1){1'b0}}, s[W-1] ^ v};
      3'b100: r = xa ^ bb;
      3'b101: r = ~(xa | bb);
      default: r = '0;
    endcase
    if (o != 3'b010) v = 1'b0;
    return {r, c, v, (r == '0), r[W-1]};
  endfunction

  // out_ready: 0 always 1, 1 pattern 1,0,0,1, 2 always 0, 3 random
  always @(posedge clk) begin
    #1;
    cyc++;
    case (or_mode)
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       out_ready = 1'b0;
      3:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [19:0] e;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'((q.size() < ST) || out_ready));
      if (prev_stall) chk("hold", 32'({result, cout, overflow, zero, negative}), 32'(held));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("stale_beat", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          e = q.pop_front();
          chk("result", 32'(result), 32'(e[19:4]));
          chk("flags", 32'({cout, overflow, zero, negative}), 32'(e[3:0]));
        end
      end
      prev_stall = out_valid & ~out_ready;
      held       = {result, cout, overflow, zero, negative};
      if (in_valid && in_ready) q.push_back(model(op, a, b, cin, bnegate));
    end
  end

  task automatic send(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic xc, input logic xn);
    op = o; a = xa; b = xb; cin = xc; bnegate = xn;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) return;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    n_total = 0; n_bad = 0; or_mode = 0; cyc = 0; prev_stall = 1'b0; held = '0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; bnegate = 1'b0; op = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_zero",      32'(zero),      32'd0);
    @(posedge clk); #1;

    // ADD and latency
    send(3'b010, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("latency", 32'(n), 32'(ST));
    wait_drain();

    // SUB overflow, SLT both orders, logic ops, unused opcodes, back-to-back
    @(posedge clk); #1;
    send(3'b010, 16'h8000, 16'h0001, 1'b1, 1'b1);
    send(3'b011, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
    send(3'b011, 16'h0001, 16'hFFFF, 1'b1, 1'b1);
    send(3'b000, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    send(3'b001, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    send(3'b100, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    send(3'b101, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    send(3'b110, 16'h1234, 16'h5678, 1'b1, 1'b0);
    send(3'b111, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    send(3'b010, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(3'b010, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_drain();

    // Streamed ADDs under 1,0,0,1 back-pressure
    or_mode = 1;
    for (int i = 0; i < 8; i++) send(3'b010, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    wait_drain();

    // Random op mix under random back-pressure
    or_mode = 3;
    for (int i = 0; i < 40; i++)
      send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    wait_drain();

    // Reset with three beats in flight
    or_mode = 2;
    @(posedge clk); #1;
    send(3'b010, 16'h0001, 16'h0002, 1'b0, 1'b0);
    send(3'b010, 16'h0003, 16'h0004, 1'b0, 1'b0);
    send(3'b001, 16'h00F0, 16'h000F, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    or_mode = 0;
    repeat (12) @(posedge clk);
    chk("flush_queue", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
